alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered pipeline stage directly downstream of the arithmetic right shifter and the other ALU datapath units.
- Captures the combinational result `y` together with the unit's carry and overflow.
- Derives the N and Z flags itself.
- Presents result plus flags to the consumer (display/register-file writeback) through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered `in_ready`.

Parameters:
- WIDTH, 4, datapath width of `y` (matches the shifter width).
- CNT_WIDTH, 8, width of the accepted-result counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept; registered.
- in_y  input  WIDTH  ALU/shifter result.
- in_c  input  1  carry/shifted-out bit from the producing unit.
- in_v  input  1  overflow from the producing unit.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts.
- out_y  output  WIDTH  registered result.
- out_flags  output  4  {N,Z,C,V}.
- xfer_count  output  CNT_WIDTH  number of results accepted at the input since reset.

Behaviour:
- Reset (rst_n low, asynchronous, dominates everything):
  - State EMPTY.
  - `out_valid` = 0, `out_y` = 0, `out_flags` = 0, `xfer_count` = 0, skid registers = 0, `in_ready` = 1.
  - Reset mid-transfer drops all held entries; no partial output.
- Flag computation at capture time:
  - N = in_y[WIDTH-1].
  - Z = (in_y == 0).
  - C = in_c.
  - V = in_v.
  - Flags are stored with their result and never recomputed later.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready. Both evaluated at the same clk edge.
- States (held entries):
  - EMPTY: out_valid = 0, in_ready = 1. Accept -> load main register; go to ONE.
  - ONE: out_valid = 1, in_ready = 1.
    - Accept & Emit -> main reloads with the new entry; stay in ONE.
    - Accept only -> new entry goes into the skid register; go to FULL.
    - Emit only -> go to EMPTY.
    - Neither -> hold.
  - FULL: out_valid = 1, in_ready = 0.
    - Emit -> skid moves to main; go to ONE.
    - Otherwise hold.
    - `in_valid` is ignored (no accept possible).
- Latency:
  - Input accepted at edge k is visible on out_* after edge k (1 cycle) when the stage was EMPTY.
  - Throughput: 1 per cycle while out_ready = 1.
- Ordering: strict FIFO; skid data never overtakes main.
- Output stability: out_y and out_flags must not change while out_valid = 1 and out_ready = 0.
- in_ready is a register output, computed as next_state != FULL.
- xfer_count:
  - Increments by 1 on every Accept.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
  - Unaffected by Emit.
- out_y and out_flags hold their last value when EMPTY (out_valid = 0). Consumers must qualify with out_valid.
- X/unknown on in_y while in_valid = 0 must not propagate into the registers.

Decomposition:
- Shared ALU package (alu_pkg):
  - typedef for the flag vector `flags_t` as a packed struct {n,z,c,v}.
  - Flag bit index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0.
  - Enum `stage_state_t` {EMPTY, ONE, FULL}.
- One sub-module: alu_flag_gen, combinational; derives flags_t from in_y, in_c, in_v; reused by other ALU stages.
- Storage and FSM stay in alu_result_stage.

Test Plan:
- Reset mid-FULL, then release:
  - Fill two entries with out_ready = 0, assert rst_n = 0.
  - Required immediately, without a clock: out_valid = 0, in_ready = 1, xfer_count = 0, out_flags = 4'b0000.
- Single transfer, WIDTH = 4:
  - in_y = 4'b1100, in_c = 0, in_v = 0 (shifter result of 4'b1000 >>> 1), out_ready = 1.
  - One cycle later: out_y = 4'b1100, out_flags = 4'b1000, out_valid = 1 for 1 cycle.
- Zero flag:
  - in_y = 4'b0000, in_c = 1 (4'b0001 >>> 1).
  - Required: out_flags = 4'b0110.
- Backpressure and skid:
  - out_ready = 0; present 4'b1110 then 4'b0001.
  - Required: in_ready falls to 0 after the second accept; the third input is held off.
  - Raise out_ready: outputs 4'b1110, then 4'b0001, in order.
  - out_y stays stable while stalled.
- Streaming:
  - 20 back-to-back inputs with in_valid = 1, out_ready = 1.
  - Required: 20 outputs on consecutive cycles, in_ready constantly 1, xfer_count = 20.
- Counter wrap:
  - CNT_WIDTH = 2; accept 5 results.
  - Required: xfer_count sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag vector layout, flag bit positions and the
// result-stage occupancy states.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational N/Z/C/V derivation for an ALU result; shared by the ALU
// pipeline stages so every stage agrees on flag meaning.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] y,
  input  logic             c,
  input  logic             v,
  output logic [3:0]       flags
);

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = y[WIDTH-1];
    flags[FLAG_Z] = (y == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: captures result and flags, hands them to the
// consumer over valid/ready with a 2-entry skid buffer and registered in_ready.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_c,
  input  logic                 in_v,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic [3:0]           out_flags,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  stage_state_t   state, next_state;
  logic [WIDTH-1:0] main_y, skid_y;
  flags_t         main_flags, skid_flags;
  flags_t         new_flags;
  logic [3:0]     gen_flags;
  logic           in_ready_q;
  logic           accept, emit;
  logic           load_main, load_skid, move_skid;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .y     (in_y),
    .c     (in_c),
    .v     (in_v),
    .flags (gen_flags)
  );

  assign new_flags = flags_t'(gen_flags);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_y     = main_y;
  assign out_flags = main_flags;

  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main  = 1'b1;
          next_state = ONE;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (emit) begin
          next_state = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          move_skid  = 1'b1;
          next_state = ONE;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Registers only load on an accept, so unknown in_y while idle never lands here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_y     <= '0;
      main_flags <= '0;
      skid_y     <= '0;
      skid_flags <= '0;
      xfer_count <= '0;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != FULL);
      if (load_main) begin
        main_y     <= in_y;
        main_flags <= new_flags;
      end else if (move_skid) begin
        main_y     <= skid_y;
        main_flags <= skid_flags;
      end
      if (load_skid) begin
        skid_y     <= in_y;
        skid_flags <= new_flags;
      end
      if (accept) begin
        xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic against a queue-based model of the stage.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_y;
  logic       in_c;
  logic       in_v;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic [3:0] out_flags;
  logic [7:0] xfer_count;

  logic       s_in_ready;
  logic       s_out_valid;
  logic [3:0] s_out_y;
  logic [3:0] s_out_flags;
  logic [1:0] s_xfer_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic [3:0] last_y;
  logic [3:0] last_f;
  int         cnt;

  alu_result_stage #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_c       (in_c),
    .in_v       (in_v),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_flags  (out_flags),
    .xfer_count (xfer_count)
  );

  // Narrow-counter copy sharing all inputs, used to watch the counter wrap.
  alu_result_stage #(.WIDTH(4), .CNT_WIDTH(2)) dut_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_y       (in_y),
    .in_c       (in_c),
    .in_v       (in_v),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_y      (s_out_y),
    .out_flags  (s_out_flags),
    .xfer_count (s_xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_flags(logic [3:0] y, logic c, logic v);
    return {y >= 4'd8, y == 4'd0, c, v};
  endfunction

  task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_y = 4'd0;
    last_f = 4'd0;
    cnt    = 0;
  endtask

  task automatic checkOutput(string tag);
    compare({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
    compare({tag, ".in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
    compare({tag, ".out_y"}, 32'(out_y), 32'(last_y));
    compare({tag, ".out_flags"}, 32'(out_flags), 32'(last_f));
    compare({tag, ".xfer_count"}, 32'(xfer_count), 32'(cnt % 256));
    compare({tag, ".small_count"}, 32'(s_xfer_count), 32'(cnt % 4));
  endtask

  // One clock of traffic: drive inputs, advance the model, check outputs.
  task automatic applyStimulus(string tag, logic v_in, logic [3:0] y, logic c, logic v, logic rdy);
    bit acc, emt;
    in_valid  = v_in;
    in_y      = v_in ? y : 4'bxxxx;
    in_c      = c;
    in_v      = v;
    out_ready = rdy;
    acc = v_in && (mq.size() < 2);
    emt = rdy && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (emt) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({y, ref_flags(y, c, v)});
      cnt++;
    end
    if (mq.size() > 0) begin
      last_y = mq[0][7:4];
      last_f = mq[0][3:0];
    end
    checkOutput(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] wrap_exp[5];
    int start;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    in_valid  = 1'b0;
    in_y      = 4'd0;
    in_c      = 1'b0;
    in_v      = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #12;
    checkOutput("reset");
    rst_n = 1'b1;

    // Single transfer of an arithmetic shift result.
    applyStimulus("single", 1'b1, 4'b1100, 1'b0, 1'b0, 1'b1);
    compare("single.flags_const", 32'(out_flags), 32'(4'b1000));
    compare("single.y_const", 32'(out_y), 32'(4'b1100));
    applyStimulus("single_drain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    applyStimulus("zero", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    compare("zero.flags_const", 32'(out_flags), 32'(4'b0110));
    applyStimulus("zero_drain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Backpressure: two accepted, third held off while stalled.
    applyStimulus("bp1", 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0);
    applyStimulus("bp2", 1'b1, 4'b0001, 1'b0, 1'b1, 1'b0);
    compare("bp.in_ready_low", 32'(in_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_stall", 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
      compare("bp.stable_y", 32'(out_y), 32'(4'b1110));
    end
    applyStimulus("bp_release1", 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1);
    compare("bp.second_out", 32'(out_y), 32'(4'b0001));
    applyStimulus("bp_release2", 1'b1, 4'b0101, 1'b1, 1'b0, 1'b1);
    applyStimulus("bp_release3", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("bp_release4", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Streaming: one result per cycle.
    start = cnt;
    for (int i = 0; i < 20; i++) begin
      applyStimulus("stream", 1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      compare("stream.in_ready", 32'(in_ready), 32'(1));
    end
    compare("stream.count", 32'(xfer_count), 32'((start + 20) % 256));
    applyStimulus("stream_drain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 3) != 0), 4'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    // Reset while FULL, checked immediately without a clock edge.
    applyStimulus("fill1", 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0);
    applyStimulus("fill2", 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
    applyStimulus("fill3", 1'b1, 4'b0111, 1'b0, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async_reset");
    compare("async_reset.flags_zero", 32'(out_flags), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("after_reset", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Counter wrap on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus("wrap", 1'b1, 4'(i), 1'b0, 1'b0, 1'b1);
      compare("wrap.seq", 32'(s_xfer_count), 32'(wrap_exp[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
